// File: rtl/metropolis_pipe_if.sv
// rtl/metropolis_pipe_if.sv - trial/result bundle between the delta calculator, one Metropolis stage and the exchange ring
interface metropolis_pipe_if #(
  parameter int DW = 27,
  parameter int TW = 32
);
  typedef struct packed {
    logic [7:0] k;
    logic [7:0] l;
    logic [1:0] command;
  } opt_t;

  logic          in_valid;
  logic [1:0]    command;
  logic          metropolis_test;
  logic          shift_distance;
  logic          exchange_valid;
  opt_t          in_opt;
  logic [DW-1:0] delta_distance;
  logic [31:0]   r_metropolis;
  logic [TW-1:0] prev_data;
  logic [TW-1:0] folw_data;
  logic          out_valid;
  opt_t          out_opt;
  logic          accept;
  logic [TW-1:0] out_data;
  logic [31:0]   trial_cnt;
  logic [31:0]   accept_cnt;

  modport master (
    output in_valid, command, metropolis_test, shift_distance, exchange_valid,
           in_opt, delta_distance, r_metropolis, prev_data, folw_data,
    input  out_valid, out_opt, accept, out_data, trial_cnt, accept_cnt
  );

  modport slave (
    input  in_valid, command, metropolis_test, shift_distance, exchange_valid,
           in_opt, delta_distance, r_metropolis, prev_data, folw_data,
    output out_valid, out_opt, accept, out_data, trial_cnt, accept_cnt
  );
endinterface

// File: rtl/metropolis_pipe.sv
// rtl/metropolis_pipe.sv - 3-stage Metropolis acceptance (2^-y via LUT + shift), total-distance update and move forwarding
// Optional statistics counters are built when METROPOLIS_STATS_EN is defined.
module metropolis_pipe #(
  parameter int          ID       = 0,
  parameter logic [15:0] DBETA    = 16'd64,
  parameter int          DW       = 27,
  parameter int          TW       = 32,
  parameter int          LUT_BITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  metropolis_pipe_if.slave bus
);
  localparam logic [1:0] CMD_PREV = 2'd1;
  localparam logic [1:0] CMD_FOLW = 2'd2;
  localparam logic [1:0] OPT_THR  = 2'd0;
  localparam logic [1:0] OPT_TWO  = 2'd1;
  localparam logic [1:0] OPT_OR0  = 2'd2;
  localparam logic [1:0] OPT_OR1  = 2'd3;

  localparam int LUTN = 1 << LUT_BITS;
  localparam int BW   = 18 + $clog2(ID + 2);
  localparam int PW   = DW + BW;
  localparam int YW   = PW + 10;
  localparam logic signed [BW-1:0] BETA  = BW'((ID + 1) * int'(DBETA));
  localparam logic signed [9:0]    LOG2E = 10'sh171;

  typedef struct packed {
    logic          valid;
    logic          neg;
    logic          mt;
    logic          shift;
    logic          ev;
    logic [1:0]    xcmd;
    logic [7:0]    k;
    logic [7:0]    l;
    logic [1:0]    ocmd;
    logic [DW-1:0] delta;
    logic [31:0]   r;
  } ctl_t;

  function automatic logic [31:0] lut_entry(int i);
    if (i == 0) return 32'hFFFF_FFFF;
    return 32'(longint'(2.0 ** (32.0 - real'(i) / real'(LUTN))));
  endfunction

  logic [31:0] lut [LUTN];
  for (genvar g = 0; g < LUTN; g++) begin : g_lut
    localparam logic [31:0] ENTRY = lut_entry(g);
    assign lut[g] = ENTRY;
  end

  ctl_t                 s1_q, s1_d, s2_q, s2_d;
  logic signed [PW-1:0] p_q, p_d, d_ext;
  logic [31:0]          thr_q, thr_d;
  logic signed [YW-1:0] y_full;
  logic [5:0]           n;
  logic [LUT_BITS-1:0]  f;
  logic                 test;
  logic                 out_valid_q, out_valid_d, accept_q, accept_d;
  logic [TW-1:0]        out_data_q, out_data_d;
  logic [7:0]           out_k_q, out_k_d, out_l_q, out_l_d;
  logic [1:0]           out_cmd_q, out_cmd_d;
  logic                 unused_bits;

  always_comb begin
    s1_d = '{valid: bus.in_valid,
             neg:   bus.delta_distance[DW-1] | (bus.delta_distance == '0),
             mt:    bus.metropolis_test,
             shift: bus.shift_distance,
             ev:    bus.exchange_valid,
             xcmd:  bus.command,
             k:     bus.in_opt.k,
             l:     bus.in_opt.l,
             ocmd:  bus.in_opt.command,
             delta: bus.delta_distance,
             r:     bus.r_metropolis};
    d_ext = PW'($signed(bus.delta_distance));
    p_d   = -d_ext * PW'(BETA);
  end

  // y is Q.25 after dropping the 8 LOG2E fraction bits; a negative y only arises when neg already accepts.
  always_comb begin
    s2_d   = s1_q;
    y_full = -YW'(p_q) * YW'(LOG2E);
    n      = '0;
    f      = '0;
    if (!y_full[YW-1]) begin
      n = (|y_full[YW-2:39]) ? 6'd63 : y_full[38:33];
      f = y_full[32 -: LUT_BITS];
    end
    thr_d = n[5] ? 32'd0 : (lut[f] >> n[4:0]);
  end

  assign unused_bits = ^y_full[32-LUT_BITS:0];

  always_comb begin
    test        = s2_q.neg | (s2_q.r < thr_q);
    out_valid_d = s2_q.valid;
    accept_d    = s2_q.valid & test & s2_q.ev;
    out_data_d  = out_data_q;
    out_k_d     = out_k_q;
    out_l_d     = out_l_q;
    out_cmd_d   = out_cmd_q;
    if (s2_q.valid) begin
      out_k_d = s2_q.k;
      out_l_d = s2_q.l;
      if (!s2_q.ev || !test)           out_cmd_d = OPT_THR;
      else if (s2_q.ocmd == OPT_TWO)   out_cmd_d = OPT_TWO;
      else                             out_cmd_d = (s2_q.k < s2_q.l) ? OPT_OR0 : OPT_OR1;
      // Neighbour totals are taken live here so ring shifts see the current values.
      if (s2_q.shift)                  out_data_d = bus.prev_data;
      else if (!s2_q.ev)               out_data_d = out_data_q;
      else if (s2_q.xcmd == CMD_PREV)  out_data_d = bus.prev_data;
      else if (s2_q.xcmd == CMD_FOLW)  out_data_d = bus.folw_data;
      else if (s2_q.mt && test)        out_data_d = out_data_q + TW'($signed(s2_q.delta));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      p_q         <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      accept_q    <= 1'b0;
      out_data_q  <= '0;
      out_k_q     <= '0;
      out_l_q     <= '0;
      out_cmd_q   <= OPT_THR;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      p_q         <= p_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      accept_q    <= accept_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
      out_l_q     <= out_l_d;
      out_cmd_q   <= out_cmd_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.accept    = accept_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_opt   = {out_k_q, out_l_q, out_cmd_q};

`ifdef METROPOLIS_STATS_EN
  logic [31:0] trial_cnt_q, trial_cnt_d, accept_cnt_q, accept_cnt_d;

  always_comb begin
    trial_cnt_d  = trial_cnt_q;
    accept_cnt_d = accept_cnt_q;
    if (s2_q.valid && s2_q.mt && s2_q.ev) begin
      if (trial_cnt_q != '1)          trial_cnt_d  = trial_cnt_q + 32'd1;
      if (test && accept_cnt_q != '1) accept_cnt_d = accept_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trial_cnt_q  <= '0;
      accept_cnt_q <= '0;
    end else begin
      trial_cnt_q  <= trial_cnt_d;
      accept_cnt_q <= accept_cnt_d;
    end
  end

  assign bus.trial_cnt  = trial_cnt_q;
  assign bus.accept_cnt = accept_cnt_q;
`else
  assign bus.trial_cnt  = '0;
  assign bus.accept_cnt = '0;
`endif
endmodule

// File: tb/tb_metropolis_pipe.sv
// tb/tb_metropolis_pipe.sv - self-checking bench for metropolis_pipe against a trial-level reference model
module tb_metropolis_pipe;
  localparam int ID    = 0;
  localparam int DBETA = 256;
  localparam int DW    = 27;
  localparam int ONE   = 1 << 17;
  localparam logic [1:0] X_NONE = 2'd0, X_PREV = 2'd1, X_FOLW = 2'd2;
  localparam logic [1:0] O_THR = 2'd0, O_TWO = 2'd1, O_OR0 = 2'd2, O_OR1 = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  metropolis_pipe_if #(.DW(DW), .TW(32)) bus ();
  metropolis_pipe #(.ID(ID), .DBETA(16'(DBETA)), .DW(DW), .TW(32), .LUT_BITS(6)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          delta;
    logic [31:0] r;
    bit          mt, ev, shift;
    logic [1:0]  xcmd;
    logic [7:0]  k, l;
    logic [1:0]  oc;
  } trial_t;

  trial_t      tq[$];
  logic        o_valid[$], o_acc[$];
  logic [31:0] o_data[$];
  logic [17:0] o_opt[$];
  logic        early_v;
  int          errors = 0, checks = 0;
  logic [31:0] exp_data, exp_prev, exp_folw;

  function automatic trial_t mk(int delta, logic [31:0] r, bit mt, bit ev, bit shift,
                                logic [1:0] xcmd, logic [7:0] k, logic [7:0] l, logic [1:0] oc);
    trial_t t;
    t.delta = delta; t.r = r; t.mt = mt; t.ev = ev; t.shift = shift;
    t.xcmd = xcmd; t.k = k; t.l = l; t.oc = oc;
    return t;
  endfunction

  function automatic longint lut_ref(int f);
    if (f == 0) return 64'hFFFF_FFFF;
    return longint'(2.0 ** (32.0 - real'(f) / 64.0));
  endfunction

  // Acceptance per the fixed-point rule: thr = 2^-y with y = delta*beta*log2(e) in Q.25.
  function automatic bit m_test(int delta, logic [31:0] r);
    longint y, thr;
    int n, f;
    if (delta <= 0) return 1'b1;
    y   = (longint'(delta) * (ID + 1) * DBETA * 369) >>> 8;
    n   = int'(y >> 25);
    f   = int'((y >> 19) & 63);
    thr = (n >= 32) ? 64'd0 : (lut_ref(f) >> n);
    return longint'(r) < thr;
  endfunction

  function automatic void m_apply(trial_t t, output logic acc, output logic [1:0] oc);
    bit pass = m_test(t.delta, t.r);
    if (t.shift)              exp_data = exp_prev;
    else if (!t.ev)           exp_data = exp_data;
    else if (t.xcmd == X_PREV) exp_data = exp_prev;
    else if (t.xcmd == X_FOLW) exp_data = exp_folw;
    else if (t.mt && pass)    exp_data = exp_data + 32'(t.delta);
    acc = pass && t.ev;
    if (!t.ev || !pass)       oc = O_THR;
    else if (t.oc == O_TWO)   oc = O_TWO;
    else                      oc = (t.k < t.l) ? O_OR0 : O_OR1;
  endfunction

  task automatic idle();
    bus.in_valid = 1'b0; bus.command = X_NONE; bus.metropolis_test = 1'b0;
    bus.shift_distance = 1'b0; bus.exchange_valid = 1'b0; bus.in_opt = '0;
    bus.delta_distance = '0; bus.r_metropolis = '0;
  endtask

  task automatic play();
    int n = tq.size();
    o_valid.delete(); o_acc.delete(); o_data.delete(); o_opt.delete();
    bus.prev_data = exp_prev;
    bus.folw_data = exp_folw;
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) begin
        bus.in_valid = 1'b1; bus.delta_distance = DW'(tq[c].delta); bus.r_metropolis = tq[c].r;
        bus.metropolis_test = tq[c].mt; bus.exchange_valid = tq[c].ev;
        bus.shift_distance = tq[c].shift; bus.command = tq[c].xcmd;
        bus.in_opt = {tq[c].k, tq[c].l, tq[c].oc};
      end else idle();
      @(posedge clk); #1;
      if (c == 1) early_v = bus.out_valid;
      if (c >= 2) begin
        o_valid.push_back(bus.out_valid); o_acc.push_back(bus.accept);
        o_data.push_back(bus.out_data);   o_opt.push_back(bus.out_opt);
      end
    end
  endtask

  task automatic test_reset();
    idle(); bus.prev_data = '0; bus.folw_data = '0;
    reset = 1'b1; repeat (3) @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.accept !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b want 0", bus.accept); end
    checks++; if (bus.out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", bus.out_data); end
    checks++; if (bus.out_opt !== {8'd0, 8'd0, O_THR}) begin errors++; $display("FAIL reset_out_opt: got %0h want 0", bus.out_opt); end
    checks++; if (bus.trial_cnt !== 32'd0 || bus.accept_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.trial_cnt, bus.accept_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    exp_prev = 32'(1000 * ONE); exp_folw = 32'(77 * ONE);
    tq.delete();
    tq.push_back(mk(0, 0, 0, 1, 1, X_NONE, 0, 0, O_OR0));
    tq.push_back(mk(-5 * ONE, 0, 1, 1, 0, X_NONE, 1, 2, O_OR0));
    play();
    checks++; if (early_v !== 1'b0) begin errors++; $display("FAIL basic_latency: out_valid got %b one cycle early, want 0", early_v); end
    checks++; if (o_valid[0] !== 1'b1 || o_data[0] !== 32'(1000 * ONE)) begin errors++; $display("FAIL basic_preload: got v=%b d=%0h want v=1 d=%0h", o_valid[0], o_data[0], 1000 * ONE); end
    checks++; if (o_acc[1] !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", o_acc[1]); end
    checks++; if (o_data[1] !== 32'(995 * ONE)) begin errors++; $display("FAIL basic_data: got %0h want %0h", o_data[1], 995 * ONE); end
  endtask

  task automatic test_threshold();
    tq.delete();
    tq.push_back(mk(ONE, 32'h5000_0000, 1, 1, 0, X_NONE, 0, 0, O_OR0));
    tq.push_back(mk(ONE, 32'h6000_0000, 1, 1, 0, X_NONE, 0, 0, O_OR0));
    play();
    checks++; if (o_acc[0] !== 1'b1 || o_data[0] !== 32'(996 * ONE)) begin errors++; $display("FAIL thr_low_r: got a=%b d=%0h want a=1 d=%0h", o_acc[0], o_data[0], 996 * ONE); end
    checks++; if (o_acc[1] !== 1'b0 || o_data[1] !== 32'(996 * ONE)) begin errors++; $display("FAIL thr_high_r: got a=%b d=%0h want a=0 d=%0h", o_acc[1], o_data[1], 996 * ONE); end
    checks++; if (o_opt[1][1:0] !== O_THR) begin errors++; $display("FAIL thr_reject_cmd: got %0d want %0d", o_opt[1][1:0], O_THR); end
  endtask

  task automatic test_boundaries();
    tq.delete();
    tq.push_back(mk(400 * ONE, 32'd0, 1, 1, 0, X_NONE, 0, 0, O_OR0));
    tq.push_back(mk(-ONE, 32'hFFFF_FFFF, 1, 1, 0, X_NONE, 0, 0, O_OR0));
    tq.push_back(mk(0, 32'hFFFF_FFFF, 1, 1, 0, X_NONE, 0, 0, O_OR0));
    play();
    checks++; if (o_acc[0] !== 1'b0 || o_data[0] !== 32'(996 * ONE)) begin errors++; $display("FAIL sat_reject: got a=%b d=%0h want a=0 d=%0h", o_acc[0], o_data[0], 996 * ONE); end
    checks++; if (o_acc[1] !== 1'b1 || o_data[1] !== 32'(995 * ONE)) begin errors++; $display("FAIL rmax_neg_accept: got a=%b d=%0h want a=1 d=%0h", o_acc[1], o_data[1], 995 * ONE); end
    checks++; if (o_acc[2] !== 1'b1) begin errors++; $display("FAIL zero_delta_accept: got %b want 1", o_acc[2]); end
  endtask

  task automatic test_opt();
    tq.delete();
    tq.push_back(mk(-ONE, 0, 0, 1, 0, X_NONE, 8'd7, 8'd3, O_OR0));
    tq.push_back(mk(-ONE, 0, 0, 1, 0, X_NONE, 8'd2, 8'd9, O_OR1));
    tq.push_back(mk(-ONE, 0, 0, 1, 0, X_NONE, 8'd5, 8'd5, O_TWO));
    tq.push_back(mk(-ONE, 0, 1, 0, 0, X_NONE, 8'd1, 8'd4, O_OR0));
    play();
    checks++; if (o_opt[0] !== {8'd7, 8'd3, O_OR1}) begin errors++; $display("FAIL opt_or1: got %0h want %0h", o_opt[0], {8'd7, 8'd3, O_OR1}); end
    checks++; if (o_opt[1] !== {8'd2, 8'd9, O_OR0}) begin errors++; $display("FAIL opt_or0: got %0h want %0h", o_opt[1], {8'd2, 8'd9, O_OR0}); end
    checks++; if (o_opt[2][1:0] !== O_TWO) begin errors++; $display("FAIL opt_two: got %0d want %0d", o_opt[2][1:0], O_TWO); end
    checks++; if (o_opt[3][1:0] !== O_THR || o_acc[3] !== 1'b0) begin errors++; $display("FAIL opt_noexch: got cmd=%0d a=%b want cmd=0 a=0", o_opt[3][1:0], o_acc[3]); end
    checks++; if (o_data[3] !== 32'(995 * ONE)) begin errors++; $display("FAIL opt_noexch_hold: got %0h want %0h", o_data[3], 995 * ONE); end
  endtask

  task automatic test_back_to_back();
    int want [4] = '{994, 992, 992, 989};
    tq.delete();
    tq.push_back(mk(-ONE, 0, 1, 1, 0, X_NONE, 0, 1, O_OR0));
    tq.push_back(mk(-2 * ONE, 0, 1, 1, 0, X_NONE, 0, 1, O_OR0));
    tq.push_back(mk(0, 0, 1, 1, 0, X_NONE, 0, 1, O_OR0));
    tq.push_back(mk(-3 * ONE, 0, 1, 1, 0, X_NONE, 0, 1, O_OR0));
    play();
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_valid[i] !== 1'b1 || o_data[i] !== 32'(want[i] * ONE)) begin errors++; $display("FAIL b2b_%0d: got v=%b d=%0h want v=1 d=%0h", i, o_valid[i], o_data[i], want[i] * ONE); end
    end
    checks++; if (o_valid[4] !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid: got %b want 0", o_valid[4]); end
  endtask

  task automatic test_random();
    logic acc;
    logic [1:0] oc;
    int sel;
    exp_data = 32'(989 * ONE);
    exp_prev = $urandom; exp_folw = $urandom;
    tq.delete();
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 9));
      tq.push_back(mk(int'($urandom_range(0, 1 << 22)) - (1 << 21), $urandom,
                      $urandom_range(0, 4) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                      (sel == 0) ? X_PREV : (sel == 1) ? X_FOLW : X_NONE,
                      8'($urandom), 8'($urandom), 2'($urandom)));
    end
    play();
    for (int i = 0; i < 60; i++) begin
      m_apply(tq[i], acc, oc);
      checks++; if (o_valid[i] !== 1'b1 || o_acc[i] !== acc) begin errors++; $display("FAIL rand_accept_%0d: got v=%b a=%b want v=1 a=%b", i, o_valid[i], o_acc[i], acc); end
      checks++; if (o_data[i] !== exp_data) begin errors++; $display("FAIL rand_data_%0d: got %0h want %0h", i, o_data[i], exp_data); end
      checks++; if (o_opt[i] !== {tq[i].k, tq[i].l, oc}) begin errors++; $display("FAIL rand_opt_%0d: got %0h want %0h", i, o_opt[i], {tq[i].k, tq[i].l, oc}); end
    end
  endtask

  task automatic test_reset_flight();
    logic seen = 1'b0;
    logic [31:0] want_tc, want_ac;
    exp_prev = '0; exp_folw = '0;
    bus.prev_data = '0; bus.folw_data = '0;
    bus.in_valid = 1'b1; bus.delta_distance = DW'(-ONE); bus.r_metropolis = '0;
    bus.metropolis_test = 1'b1; bus.exchange_valid = 1'b1; bus.shift_distance = 1'b0;
    bus.command = X_NONE; bus.in_opt = '0;
    repeat (2) begin @(posedge clk); #1; end
    idle(); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0) begin errors++; $display("FAIL flight_reset_state: got v=%b d=%0h want v=0 d=0", bus.out_valid, bus.out_data); end
    checks++; if (bus.trial_cnt !== 32'd0 || bus.accept_cnt !== 32'd0) begin errors++; $display("FAIL flight_counters_clear: got %0d/%0d want 0/0", bus.trial_cnt, bus.accept_cnt); end
    repeat (4) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flight_discarded: got out_valid after reset, want none"); end
    tq.delete();
    tq.push_back(mk(-ONE, 0, 1, 1, 0, X_NONE, 0, 1, O_OR0));
    tq.push_back(mk(-2 * ONE, 0, 1, 1, 0, X_NONE, 0, 1, O_OR0));
    tq.push_back(mk(0, 0, 1, 1, 0, X_NONE, 0, 1, O_OR0));
    tq.push_back(mk(-3 * ONE, 0, 1, 1, 0, X_NONE, 0, 1, O_OR0));
    play();
    checks++; if (o_data[3] !== 32'(-6 * ONE)) begin errors++; $display("FAIL flight_rerun_data: got %0h want %0h", o_data[3], 32'(-6 * ONE)); end
`ifdef METROPOLIS_STATS_EN
    want_tc = 32'd4; want_ac = 32'd4;
`else
    want_tc = 32'd0; want_ac = 32'd0;
`endif
    checks++; if (bus.trial_cnt !== want_tc || bus.accept_cnt !== want_ac) begin errors++; $display("FAIL flight_counters: got %0d/%0d want %0d/%0d", bus.trial_cnt, bus.accept_cnt, want_tc, want_ac); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_prev = '0; exp_folw = '0; exp_data = '0; early_v = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_threshold();
    test_boundaries();
    test_opt();
    test_back_to_back();
    test_random();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
